five_bit_counter: RTL and testbench

FIVE_BIT_COUNTER -- requirements
Module: five_bit_counter

---
 rtl/five_bit_counter.sv | 50 +++++
 tb/tb_five_bit_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/five_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : five_bit_counter
// Purpose  : Saturating 5-bit up/down counter with parallel load and
//            zero/full flags.
// Revision : 1.0 - initial release
// ============================================================================

module five_bit_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] in,
  input  logic       load,
  input  logic       down,
  input  logic       up,
  output logic [4:0] counter,
  output logic       low,
  output logic       high
);

  localparam logic [4:0] C_MIN = 5'd0;
  localparam logic [4:0] C_MAX = 5'd31;

  logic [4:0] r_count;
  logic [4:0] w_next;

  // Priority: load, then down, then up; both directions saturate at the ends.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = in;
    end else if (down) begin
      if (r_count != C_MIN) w_next = r_count - 5'd1;
    end else if (up) begin
      if (r_count != C_MAX) w_next = r_count + 5'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_count <= C_MIN;
    else          r_count <= w_next;
  end

  assign counter = r_count;
  assign low     = (r_count == C_MIN);
  assign high    = (r_count == C_MAX);

endmodule

`default_nettype wire

// File: tb/tb_five_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_five_bit_counter
// Purpose  : Self-checking bench for five_bit_counter (directed + random).
// Revision : 1.0 - initial release
// ============================================================================

module tb_five_bit_counter;

  logic       clock;
  logic       reset_n;
  logic [4:0] in;
  logic       load;
  logic       down;
  logic       up;
  logic [4:0] counter;
  logic       low;
  logic       high;

  int n_total;
  int n_bad;
  int model;

  five_bit_counter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .down    (down),
    .up      (up),
    .counter (counter),
    .low     (low),
    .high    (high)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".counter"}, int'(counter), model);
    chk({tag, ".low"}, int'(low), (model == 0) ? 1 : 0);
    chk({tag, ".high"}, int'(high), (model == 31) ? 1 : 0);
  endtask

  // One clock: drive inputs, take the edge, update the reference, check at negedge.
  task automatic step(input logic l, input logic d, input logic u, input logic [4:0] v);
    load = l; down = d; up = u; in = v;
    @(posedge clock);
    if (reset_n) begin
      if (l)      model = int'(v);
      else if (d) model = (model > 0) ? model - 1 : 0;
      else if (u) model = (model < 31) ? model + 1 : 31;
    end
    @(negedge clock);
  endtask

  initial begin
    n_total = 0; n_bad = 0; model = 0;
    reset_n = 1'b0; load = 1'b1; down = 1'b0; up = 1'b1; in = 5'd17;

    // Reset holds the count at zero even with load requested across edges.
    repeat (3) @(negedge clock);
    chk_all("reset_hold");
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("after_release");

    step(1'b1, 1'b0, 1'b0, 5'b10111);
    chk_all("load23");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd23);
      chk("load_prio", int'(counter), 23);
    end
    step(1'b0, 1'b1, 1'b1, 5'd0);
    chk("down_over_up", int'(counter), 22);
    step(1'b1, 1'b0, 1'b0, 5'd23);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    chk("down_only", int'(counter), 22);
    step(1'b1, 1'b0, 1'b0, 5'd23);
    step(1'b0, 1'b0, 1'b1, 5'd0);
    chk("up", int'(counter), 24);
    step(1'b0, 1'b0, 1'b0, 5'd9);
    chk_all("hold");

    step(1'b1, 1'b0, 1'b0, 5'd22);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
    chk("low_sat.counter", int'(counter), 0);
    chk("low_sat.low", int'(low), 1);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    chk_all("low_sat_stay");

    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 5'd0);
    chk("high_sat.counter", int'(counter), 31);
    chk("high_sat.high", int'(high), 1);
    step(1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("high_sat_stay");

    step(1'b1, 1'b0, 1'b0, 5'd0);
    chk_all("load0_low");
    step(1'b1, 1'b0, 1'b0, 5'd31);
    chk_all("load31_high");

    // Asynchronous reset mid-count: must clear between clock edges.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    model = 0;
    #1;
    chk_all("async_reset");
    step(1'b1, 1'b0, 1'b1, 5'd12);
    chk_all("reset_overrides");
    reset_n = 1'b1;

    // Randomized traffic, occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      logic l, d, u;
      logic [4:0] v;
      l = ($urandom_range(0, 9) == 0);
      d = $urandom_range(0, 1);
      u = $urandom_range(0, 1);
      v = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        #1;
        reset_n = 1'b0;
        model = 0;
        #1;
        chk_all("rand_reset");
        @(negedge clock);
        reset_n = 1'b1;
      end
      step(l, d, u, v);
      chk_all("rand");
      if (low && high) chk("flags_exclusive", 1, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
